// File: rtl/clock_pkg.sv
// ---------------------------------------------------------------------------
// clock_pkg
// Shared definitions for the DCM_CLKGEN programming sequencer:
//   - state_t       : sequencer state encoding
//   - CMD_LOAD_D/M  : 2-bit command codes, sent bit 0 first
//   - LOAD_LEN      : length of one LoadD/LoadM frame (2 command + 8 data bits)
//   - RETRY_CYCLES  : settle time after a DCM reset before replaying
//   - build_frame() : packs a command code and a value into a shift frame
// No ports (package).
// ---------------------------------------------------------------------------
package clock_pkg;

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_LOAD_D     = 3'd1;
  localparam logic [2:0] S_GAP_D      = 3'd2;
  localparam logic [2:0] S_LOAD_M     = 3'd3;
  localparam logic [2:0] S_GAP_M      = 3'd4;
  localparam logic [2:0] S_GO         = 3'd5;
  localparam logic [2:0] S_WAIT_DONE  = 3'd6;
  localparam logic [2:0] S_RETRY_WAIT = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE       = S_IDLE,
    ST_LOAD_D     = S_LOAD_D,
    ST_GAP_D      = S_GAP_D,
    ST_LOAD_M     = S_LOAD_M,
    ST_GAP_M      = S_GAP_M,
    ST_GO         = S_GO,
    ST_WAIT_DONE  = S_WAIT_DONE,
    ST_RETRY_WAIT = S_RETRY_WAIT
  } state_t;

  localparam logic [1:0] CMD_LOAD_D   = 2'b01;
  localparam logic [1:0] CMD_LOAD_M   = 2'b11;
  localparam int         LOAD_LEN     = 10;
  localparam int         RETRY_CYCLES = 8;

  // The frame leaves LSB first, so the command code sits in the low bits
  // and the value follows it starting from its own bit 0.
  function automatic logic [LOAD_LEN-1:0] build_frame(input logic [1:0] cmd,
                                                      input logic [7:0] val);
    return {val, cmd};
  endfunction

endpackage

// File: rtl/dcm_prog_shift.sv
// ---------------------------------------------------------------------------
// dcm_prog_shift
// 10-bit load/shift register whose bit 0 drives DCM PROGDATA. A load places a
// whole frame; each shift moves the next bit into position and back-fills
// with zeros, so the line idles low once a frame has been fully sent.
// Ports:
//   clk_i    PROGCLK-domain clock
//   rst_i    asynchronous active-high reset (clears the register)
//   load_i   load frame_i (has priority over shift_i)
//   shift_i  advance to the next bit
//   frame_i  frame to load, bit 0 sent first
//   bit_o    registered serial output
// ---------------------------------------------------------------------------
module dcm_prog_shift
  import clock_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                load_i,
  input  logic                shift_i,
  input  logic [LOAD_LEN-1:0] frame_i,
  output logic                bit_o
);

  logic [LOAD_LEN-1:0] shreg_q;
  logic [LOAD_LEN-1:0] shreg_d;

  // Next contents: a load replaces the frame, a shift walks toward bit 0
  // filling the top with zeros so nothing stale is ever replayed.
  always_comb begin
    shreg_d = shreg_q;
    if (load_i) begin
      shreg_d = frame_i;
    end else if (shift_i) begin
      shreg_d = {1'b0, shreg_q[LOAD_LEN-1:1]};
    end
  end

  // Storage; the async clear forces PROGDATA low the instant reset asserts.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign bit_o = shreg_q[0];

endmodule

// File: rtl/dcm_clkgen_prog.sv
// ---------------------------------------------------------------------------
// dcm_clkgen_prog
// Sequencer for the DCM_CLKGEN dynamic-reconfiguration port. Takes one
// (multiply-1, divide-1) request, sends LoadD, LoadM and GO over
// PROGEN/PROGDATA, then waits for a rising PROGDONE or a timeout.
// Optional feature macro: DCM_PROG_RETRY_EN -- on the first timeout request a
// DCM reset, settle, and replay once before reporting an error.
// Parameters:
//   DONE_TIMEOUT  clk cycles allowed in WAIT_DONE (minimum 16, at most 4096)
// Ports:
//   clk_i          PROGCLK-domain clock, also the DCM PROGCLK
//   rst_i          asynchronous active-high reset
//   cmd_m_i        CLKFX_MULTIPLY-1 (0 is rejected)
//   cmd_d_i        CLKFX_DIVIDE-1
//   cmd_valid_i    request valid
//   cmd_ready_o    high in IDLE (low for one cycle after reset release)
//   prog_en_o      DCM PROGEN
//   prog_data_o    DCM PROGDATA
//   prog_done_i    DCM PROGDONE, synchronous to clk_i
//   dcm_rst_req_o  1-cycle DCM reset request (retry build only, else 0)
//   busy_o         high outside IDLE
//   done_o         1-cycle pulse on success
//   error_o        1-cycle pulse on a rejected request or final timeout
// ---------------------------------------------------------------------------
module dcm_clkgen_prog
  import clock_pkg::*;
#(
  parameter int DONE_TIMEOUT = 4096
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] cmd_m_i,
  input  logic [7:0] cmd_d_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  output logic       prog_en_o,
  output logic       prog_data_o,
  input  logic       prog_done_i,
  output logic       dcm_rst_req_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       error_o
);

  localparam logic [3:0]  BIT_LAST = 4'(LOAD_LEN - 1);
  localparam logic [11:0] TMO_LAST = 12'(DONE_TIMEOUT - 1);

  state_t              state_q;
  logic [3:0]          bit_cnt_q;
  logic [11:0]         tmo_q;
  logic [7:0]          m_q;
  logic [7:0]          d_q;
  logic                seen_low_q;
  logic                prog_en_q;
  logic                cmd_ready_q;
  logic                busy_q;
  logic                done_q;
  logic                error_q;
  logic                accept;
  logic                sh_load;
  logic                sh_shift;
  logic [LOAD_LEN-1:0] sh_frame;
`ifdef DCM_PROG_RETRY_EN
  localparam logic [3:0] RETRY_LAST = 4'(RETRY_CYCLES - 1);
  logic                retried_q;
  logic                dcm_rst_req_q;
`endif

  assign accept = (state_q == ST_IDLE) && cmd_ready_q && cmd_valid_i;

  // Shift-register control. Each frame is loaded on the edge that enters its
  // LOAD state so bit 0 is on PROGDATA in the first LOAD cycle; the D frame
  // comes straight from the request port on acceptance (m_q/d_q are not yet
  // written) and from the latched copy on a replay.
  always_comb begin
    sh_load  = 1'b0;
    sh_shift = 1'b0;
    sh_frame = build_frame(CMD_LOAD_D, d_q);
    case (state_q)
      ST_IDLE: begin
        if (accept && (cmd_m_i != 8'd0)) begin
          sh_load  = 1'b1;
          sh_frame = build_frame(CMD_LOAD_D, cmd_d_i);
        end
      end
      ST_LOAD_D, ST_LOAD_M: sh_shift = 1'b1;
      ST_GAP_D: begin
        sh_load  = 1'b1;
        sh_frame = build_frame(CMD_LOAD_M, m_q);
      end
`ifdef DCM_PROG_RETRY_EN
      ST_RETRY_WAIT: sh_load = (bit_cnt_q == RETRY_LAST);
`endif
      default: ;
    endcase
  end

  dcm_prog_shift u_shift (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (sh_load),
    .shift_i (sh_shift),
    .frame_i (sh_frame),
    .bit_o   (prog_data_o)
  );

  // Main sequencer. Every output is a register updated alongside the state,
  // so PROGEN changes on the same edge that enters or leaves a LOAD/GO state.
  // In WAIT_DONE a success check precedes the timeout check, so a PROGDONE
  // edge on the final allowed cycle still counts as success.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      bit_cnt_q     <= '0;
      tmo_q         <= '0;
      m_q           <= '0;
      d_q           <= '0;
      seen_low_q    <= 1'b0;
      prog_en_q     <= 1'b0;
      cmd_ready_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
`ifdef DCM_PROG_RETRY_EN
      retried_q     <= 1'b0;
      dcm_rst_req_q <= 1'b0;
`endif
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
`ifdef DCM_PROG_RETRY_EN
      dcm_rst_req_q <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          cmd_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          prog_en_q   <= 1'b0;
          if (accept) begin
            if (cmd_m_i == 8'd0) begin
              error_q <= 1'b1;
            end else begin
              m_q         <= cmd_m_i;
              d_q         <= cmd_d_i;
              state_q     <= ST_LOAD_D;
              bit_cnt_q   <= '0;
              prog_en_q   <= 1'b1;
              cmd_ready_q <= 1'b0;
              busy_q      <= 1'b1;
`ifdef DCM_PROG_RETRY_EN
              retried_q   <= 1'b0;
`endif
            end
          end
        end
        ST_LOAD_D: begin
          if (bit_cnt_q == BIT_LAST) begin
            state_q   <= ST_GAP_D;
            bit_cnt_q <= '0;
            prog_en_q <= 1'b0;
          end else begin
            bit_cnt_q <= bit_cnt_q + 4'd1;
          end
        end
        ST_GAP_D: begin
          state_q   <= ST_LOAD_M;
          bit_cnt_q <= '0;
          prog_en_q <= 1'b1;
        end
        ST_LOAD_M: begin
          if (bit_cnt_q == BIT_LAST) begin
            state_q   <= ST_GAP_M;
            bit_cnt_q <= '0;
            prog_en_q <= 1'b0;
          end else begin
            bit_cnt_q <= bit_cnt_q + 4'd1;
          end
        end
        ST_GAP_M: begin
          state_q   <= ST_GO;
          bit_cnt_q <= '0;
          prog_en_q <= 1'b1;
        end
        ST_GO: begin
          state_q    <= ST_WAIT_DONE;
          bit_cnt_q  <= '0;
          prog_en_q  <= 1'b0;
          tmo_q      <= '0;
          seen_low_q <= 1'b0;
        end
        ST_WAIT_DONE: begin
          if (seen_low_q && prog_done_i) begin
            done_q      <= 1'b1;
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
          end else if (tmo_q == TMO_LAST) begin
`ifdef DCM_PROG_RETRY_EN
            if (!retried_q) begin
              retried_q     <= 1'b1;
              dcm_rst_req_q <= 1'b1;
              state_q       <= ST_RETRY_WAIT;
              bit_cnt_q     <= '0;
            end else begin
              error_q     <= 1'b1;
              state_q     <= ST_IDLE;
              busy_q      <= 1'b0;
              cmd_ready_q <= 1'b1;
            end
`else
            error_q     <= 1'b1;
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
`endif
          end else begin
            tmo_q <= tmo_q + 12'd1;
            if (!prog_done_i) begin
              seen_low_q <= 1'b1;
            end
          end
        end
`ifdef DCM_PROG_RETRY_EN
        ST_RETRY_WAIT: begin
          if (bit_cnt_q == RETRY_LAST) begin
            state_q   <= ST_LOAD_D;
            bit_cnt_q <= '0;
            prog_en_q <= 1'b1;
          end else begin
            bit_cnt_q <= bit_cnt_q + 4'd1;
          end
        end
`endif
        default: begin
          state_q   <= ST_IDLE;
          prog_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready_o = cmd_ready_q;
  assign prog_en_o   = prog_en_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign error_o     = error_q;
`ifdef DCM_PROG_RETRY_EN
  assign dcm_rst_req_o = dcm_rst_req_q;
`else
  assign dcm_rst_req_o = 1'b0;
`endif

endmodule

// File: tb/tb_dcm_clkgen_prog.sv
// ---------------------------------------------------------------------------
// tb_dcm_clkgen_prog
// Self-checking bench for dcm_clkgen_prog with DONE_TIMEOUT=16. A monitor
// decodes PROGEN/PROGDATA bursts into LoadD/LoadM/GO and checks them against
// a queue of expected requests; stimulus comes from a vector table plus
// hand-written timeout, reset and back-to-back sequences.
// Honours DCM_PROG_RETRY_EN for the timeout expectations.
// ---------------------------------------------------------------------------
module tb_dcm_clkgen_prog;

  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] cmdM = '0;
  logic [7:0] cmdD = '0;
  logic       cmdValid = 1'b0;
  logic       progDone = 1'b0;
  logic       cmdReady, progEn, progData, dcmRstReq, busy, done, error;

  dcm_clkgen_prog #(.DONE_TIMEOUT(TMO)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .cmd_m_i       (cmdM),
    .cmd_d_i       (cmdD),
    .cmd_valid_i   (cmdValid),
    .cmd_ready_o   (cmdReady),
    .prog_en_o     (progEn),
    .prog_data_o   (progData),
    .prog_done_i   (progDone),
    .dcm_rst_req_o (dcmRstReq),
    .busy_o        (busy),
    .done_o        (done),
    .error_o       (error)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [7:0] m;
    logic [7:0] d;
  } exp_t;

  typedef struct {
    logic [7:0] m;
    logic [7:0] d;
    int         doneDelay;
    logic       expDone;
    logic       expError;
  } vec_t;

  exp_t expQ[$];
  exp_t monExp;
  vec_t vectors[7];

  int         cyc = 0;
  int         runLen = 0;
  int         runStart = 0;
  int         frameCount = 0;
  int         startD = 0;
  int         startM = 0;
  int         goCount = 0;
  logic [9:0] runBits = '0;
  logic [9:0] frameD = '0;
  logic [9:0] frameM = '0;

  // Every comparison goes through here so the counters stay in one place.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Burst decoder: 10-cycle PROGEN runs are frames, a 1-cycle run is GO.
  // On GO the oldest expected request is popped and both frames plus their
  // relative positions are checked. Reset abandons any partial burst.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      runLen     = 0;
      frameCount = 0;
    end else if (progEn) begin
      if (runLen == 0) runStart = cyc;
      if (runLen < 10) runBits[runLen] = progData;
      runLen++;
    end else if (runLen != 0) begin
      if (runLen == 10) begin
        if (frameCount == 0) begin
          frameD = runBits;
          startD = runStart;
        end else begin
          frameM = runBits;
          startM = runStart;
        end
        frameCount++;
      end else if (runLen == 1) begin
        goCount++;
        checkOutput("go_expected", 32'(expQ.size() > 0), 1);
        if (expQ.size() > 0) begin
          monExp = expQ.pop_front();
          checkOutput("frame_d", 32'(frameD), 32'({monExp.d, 2'b01}));
          checkOutput("frame_m", 32'(frameM), 32'({monExp.m, 2'b11}));
          checkOutput("frame_count", frameCount, 2);
          checkOutput("m_offset", startM - startD, 11);
          checkOutput("go_offset", runStart - startD, 22);
          checkOutput("go_data", 32'(runBits[0]), 0);
        end
        frameCount = 0;
      end else begin
        checkOutput("burst_len", runLen, 10);
      end
      runLen = 0;
    end
  end

  // Hard stop in case a sequence wedges the bench itself.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Drive one request at a negedge and hold it through the accepting edge.
  task automatic applyStimulus(input logic [7:0] m, input logic [7:0] d,
                               input bit holdValid);
    @(negedge clk);
    for (int i = 0; i < 20 && cmdReady !== 1'b1; i++) @(negedge clk);
    checkOutput("ready_before_req", 32'(cmdReady), 1);
    cmdM     = m;
    cmdD     = d;
    cmdValid = 1'b1;
    if (m != 8'd0) expQ.push_back('{m: m, d: d});
    @(posedge clk);
    #1;
    if (!holdValid) cmdValid = 1'b0;
  endtask

  // Wait (bounded) until the monitor reports the next GO.
  task automatic waitGo();
    int g0;
    g0 = goCount;
    for (int i = 0; i < 80 && goCount == g0; i++) begin
      @(negedge clk);
      #1;
    end
    checkOutput("go_seen", goCount - g0, 1);
  endtask

  // Raise PROGDONE k negedges after GO was seen and check the done pulse.
  task automatic respondDone(input int k, input logic expDone);
    repeat (k) @(negedge clk);
    checkOutput("busy_before_done", 32'(busy), 1);
    checkOutput("done_early", 32'(done), 0);
    progDone = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("done_pulse", 32'(done), 32'(expDone));
    checkOutput("done_no_error", 32'(error), 0);
    checkOutput("busy_after_done", 32'(busy), 0);
    checkOutput("ready_after_done", 32'(cmdReady), 1);
    @(posedge clk);
    #1;
    checkOutput("done_width", 32'(done), 0);
    progDone = 1'b0;
  endtask

  task automatic runVector(input vec_t v);
    applyStimulus(v.m, v.d, 1'b0);
    if (v.m == 8'd0) begin
      checkOutput("reject_error", 32'(error), 32'(v.expError));
      checkOutput("reject_no_en", 32'(progEn), 0);
      checkOutput("reject_ready", 32'(cmdReady), 1);
      checkOutput("reject_busy", 32'(busy), 0);
      @(posedge clk);
      #1;
      checkOutput("reject_error_width", 32'(error), 0);
      checkOutput("reject_no_en2", 32'(progEn), 0);
    end else begin
      waitGo();
      respondDone(v.doneDelay, v.expDone);
    end
  endtask

  // Count posedges after GO until an error, retry request or done shows up.
  task automatic countToEvent(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (n < 3 * TMO && error !== 1'b1 && dcmRstReq !== 1'b1 && done !== 1'b1);
  endtask

  // PROGDONE never rises (stale = held high from the start instead of low).
  task automatic runTimeout(input bit stale);
    int n;
    applyStimulus(8'h11, 8'h22, 1'b0);
    if (stale) progDone = 1'b1;
    waitGo();
    countToEvent(n);
    checkOutput("timeout_cycles", n, TMO);
    checkOutput("timeout_no_done", 32'(done), 0);
`ifdef DCM_PROG_RETRY_EN
    checkOutput("retry_req", 32'(dcmRstReq), 1);
    checkOutput("retry_no_error", 32'(error), 0);
    checkOutput("retry_busy", 32'(busy), 1);
    expQ.push_back('{m: 8'h11, d: 8'h22});
    @(posedge clk);
    #1;
    checkOutput("retry_req_width", 32'(dcmRstReq), 0);
    waitGo();
    countToEvent(n);
    checkOutput("timeout2_cycles", n, TMO);
    checkOutput("timeout2_error", 32'(error), 1);
    checkOutput("timeout2_no_req", 32'(dcmRstReq), 0);
`else
    checkOutput("timeout_error", 32'(error), 1);
    checkOutput("timeout_no_req", 32'(dcmRstReq), 0);
`endif
    checkOutput("timeout_busy", 32'(busy), 0);
    @(posedge clk);
    #1;
    checkOutput("timeout_error_width", 32'(error), 0);
    progDone = 1'b0;
  endtask

  initial begin
    vectors[0] = '{m: 8'd24,  d: 8'd0,   doneDelay: 5,  expDone: 1'b1, expError: 1'b0};
    vectors[1] = '{m: 8'd0,   d: 8'd55,  doneDelay: 0,  expDone: 1'b0, expError: 1'b1};
    vectors[2] = '{m: 8'hFF,  d: 8'hFF,  doneDelay: 1,  expDone: 1'b1, expError: 1'b0};
    vectors[3] = '{m: 8'h01,  d: 8'h00,  doneDelay: 15, expDone: 1'b1, expError: 1'b0};
    vectors[4] = '{m: 8'h5A,  d: 8'hA5,  doneDelay: 2,  expDone: 1'b1, expError: 1'b0};
    vectors[5] = '{m: 8'h00,  d: 8'h00,  doneDelay: 0,  expDone: 1'b0, expError: 1'b1};
    vectors[6] = '{m: 8'h80,  d: 8'h01,  doneDelay: 7,  expDone: 1'b1, expError: 1'b0};

    // Reset state, and the single not-ready cycle after release.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_prog_en", 32'(progEn), 0);
    checkOutput("rst_prog_data", 32'(progData), 0);
    checkOutput("rst_ready", 32'(cmdReady), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_done", 32'(done), 0);
    checkOutput("rst_error", 32'(error), 0);
    checkOutput("rst_dcm_req", 32'(dcmRstReq), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("ready_after_release", 32'(cmdReady), 0);
    @(posedge clk);
    #1;
    checkOutput("ready_one_cycle_later", 32'(cmdReady), 1);

    for (int i = 0; i < 7; i++) runVector(vectors[i]);

    runTimeout(1'b0);
    runTimeout(1'b1);

    // Reset during LOAD_M frame bit 5 (m[3]); m=0x48 makes that bit a 1.
    applyStimulus(8'h48, 8'h07, 1'b0);
    repeat (16) @(posedge clk);
    #1;
    checkOutput("mid_load_m_en", 32'(progEn), 1);
    checkOutput("mid_load_m_bit5", 32'(progData), 1);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_en", 32'(progEn), 0);
    checkOutput("async_rst_data", 32'(progData), 0);
    checkOutput("async_rst_busy", 32'(busy), 0);
    expQ.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rerst_ready_low", 32'(cmdReady), 0);
    @(posedge clk);
    #1;
    checkOutput("rerst_ready_high", 32'(cmdReady), 1);
    checkOutput("rerst_busy", 32'(busy), 0);
    applyStimulus(8'h2B, 8'h13, 1'b0);
    waitGo();
    respondDone(4, 1'b1);

    // cmd_valid held with new values: second transfer only after IDLE.
    applyStimulus(8'h0C, 8'h03, 1'b1);
    cmdM = 8'h21;
    cmdD = 8'h09;
    expQ.push_back('{m: 8'h21, d: 8'h09});
    repeat (3) @(posedge clk);
    #1;
    checkOutput("held_ready_low", 32'(cmdReady), 0);
    checkOutput("held_busy", 32'(busy), 1);
    waitGo();
    respondDone(3, 1'b1);
    checkOutput("second_start_en", 32'(progEn), 1);
    checkOutput("second_start_bit", 32'(progData), 1);
    checkOutput("second_busy", 32'(busy), 1);
    cmdValid = 1'b0;
    waitGo();
    respondDone(6, 1'b1);

    checkOutput("queue_drained", expQ.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
